// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
package ram_arb_pkg;

    // Width of a requester index; at least one bit so a single-bit field is never zero-wide.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Largest requester count the pending-read id field can name.
    localparam int MAX_NUM_REQ = 16;
    localparam int ID_W        = id_width(MAX_NUM_REQ);

    // One in-flight read on a RAM port: which requester gets ram_q next cycle.
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } rd_pend_t;

    // RAM port selector, also used to index the per-port pending-read registers.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } ram_port_e;

endpackage

// File: rtl/ram_arb_pick.sv
// Rotating-priority picker: first requester at or after rr_ptr that is valid and not excluded.
module ram_arb_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] rr_ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Scan rr_ptr, rr_ptr+1, ... (mod N) and stop at the first eligible requester.
    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop; a path that leaves one unassigned would infer a latch.
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!gnt_any && valid[IW'(idx)] && !excl[IW'(idx)]) begin
                gnt_any             = 1'b1;
                gnt_oh[IW'(idx)]    = 1'b1;
                gnt_idx             = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares both ports of a synchronous-read dual-port RAM among NUM_REQ requesters,
// granting up to two per cycle round-robin and routing read data back by requester id.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_REQ    = 4
) (
    input  logic                            clock,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]   rsp_rdata,
    output logic [ADDR_WIDTH-1:0]           ram_address_a,
    output logic [ADDR_WIDTH-1:0]           ram_address_b,
    output logic [DATA_WIDTH-1:0]           ram_data_a,
    output logic [DATA_WIDTH-1:0]           ram_data_b,
    output logic                            ram_wren_a,
    output logic                            ram_wren_b,
    input  logic [DATA_WIDTH-1:0]           ram_q_a,
    input  logic [DATA_WIDTH-1:0]           ram_q_b
);

    localparam int IW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    logic [IW-1:0]                      rr_ptr_q, rr_ptr_d;
    rd_pend_t                           pend_q [2];
    rd_pend_t                           pend_d [2];
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [NUM_REQ-1:0] no_excl, excl_b;
    logic [NUM_REQ-1:0] a_oh, b_oh;
    logic [IW-1:0]      a_idx, b_idx;
    logic               a_any, b_any;
    logic               gnt_a, gnt_b;

    assign no_excl = '0;

    ram_arb_pick #(.N(NUM_REQ), .IW(IW)) u_pick_a (
        .valid   (req_valid),
        .rr_ptr  (rr_ptr_q),
        .excl    (no_excl),
        .gnt_oh  (a_oh),
        .gnt_idx (a_idx),
        .gnt_any (a_any)
    );

    // Port B may not take the port-A requester nor anyone colliding with it on a write.
    always_comb begin
        excl_b = a_oh;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (a_any && (addr_v[i] == addr_v[a_idx]) && (req_wr[i] || req_wr[a_idx]))
                excl_b[i] = 1'b1;
        end
    end

    ram_arb_pick #(.N(NUM_REQ), .IW(IW)) u_pick_b (
        .valid   (req_valid),
        .rr_ptr  (rr_ptr_q),
        .excl    (excl_b),
        .gnt_oh  (b_oh),
        .gnt_idx (b_idx),
        .gnt_any (b_any)
    );

    // Nothing is granted while reset is held, so the RAM pins stay quiet.
    assign gnt_a     = a_any && rst_n;
    assign gnt_b     = b_any && rst_n;
    assign req_ready = rst_n ? (a_oh | b_oh) : '0;

    // Drive the RAM pins from the granted requester; idle ports are all-zero.
    always_comb begin
        ram_address_a = '0;
        ram_data_a    = '0;
        ram_wren_a    = 1'b0;
        ram_address_b = '0;
        ram_data_b    = '0;
        ram_wren_b    = 1'b0;
        if (gnt_a) begin
            ram_address_a = addr_v[a_idx];
            ram_wren_a    = req_wr[a_idx];
            if (req_wr[a_idx]) ram_data_a = wdata_v[a_idx];
        end
        if (gnt_b) begin
            ram_address_b = addr_v[b_idx];
            ram_wren_b    = req_wr[b_idx];
            if (req_wr[b_idx]) ram_data_b = wdata_v[b_idx];
        end
    end

    // Next pointer sits just past the last requester granted in scan order; record reads in flight.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_b)
            rr_ptr_d = IW'((int'(b_idx) + 1) % NUM_REQ);
        else if (gnt_a)
            rr_ptr_d = IW'((int'(a_idx) + 1) % NUM_REQ);
        pend_d[PORT_A] = '{vld: gnt_a && !req_wr[a_idx], id: ID_W'(a_idx)};
        pend_d[PORT_B] = '{vld: gnt_b && !req_wr[b_idx], id: ID_W'(b_idx)};
    end

    // Route ram_q to the requester that issued the read; other lanes keep their last value.
    always_comb begin
        rsp_valid = '0;
        rdata_d   = rdata_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend_q[PORT_A].vld && (pend_q[PORT_A].id == ID_W'(i))) begin
                rsp_valid[i] = 1'b1;
                rdata_d[i]   = ram_q_a;
            end
            if (pend_q[PORT_B].vld && (pend_q[PORT_B].id == ID_W'(i))) begin
                rsp_valid[i] = 1'b1;
                rdata_d[i]   = ram_q_b;
            end
        end
    end

    assign rsp_rdata = rdata_d;

    // State registers; reset drops any read that was in flight.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the RAM array lives outside this block and keeps its contents; only the
            // arbiter's own small state and held response lanes are cleared here.
            rr_ptr_q       <= '0;
            pend_q[PORT_A] <= '0;
            pend_q[PORT_B] <= '0;
            rdata_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            rr_ptr_q       <= rr_ptr_d;
            pend_q[PORT_A] <= pend_d[PORT_A];
            pend_q[PORT_B] <= pend_d[PORT_B];
            rdata_q        <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural RAM and a scan-order reference model.
module tb_ram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int N  = 4;

    logic                 clock = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid, req_wr, req_ready, rsp_valid;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_wdata, rsp_rdata;
    logic [AW-1:0]        ram_address_a, ram_address_b;
    logic [DW-1:0]        ram_data_a, ram_data_b, ram_q_a, ram_q_b;
    logic                 ram_wren_a, ram_wren_b;

    always #5 clock = ~clock;

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
        .clock(clock), .rst_n(rst_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_address_a(ram_address_a), .ram_address_b(ram_address_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_wren_a(ram_wren_a), .ram_wren_b(ram_wren_b),
        .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
    );

    // Power-on contents of every RAM word (distinct per address).
    function automatic logic [DW-1:0] init_word(input int a);
        return 32'hA500_0000 ^ (32'(a) * 32'h0001_0003);
    endfunction

    // Behavioural dual-port RAM: registered read, read-before-write.
    logic [DW-1:0] mem     [1<<AW];
    bit            written [1<<AW];
    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] ad);
        return written[ad] ? mem[ad] : init_word(int'(ad));
    endfunction
    always @(posedge clock) begin
        ram_q_a <= ram_rd(ram_address_a);
        ram_q_b <= ram_rd(ram_address_b);
        if (ram_wren_a) begin mem[ram_address_a] <= ram_data_a; written[ram_address_a] <= 1'b1; end
        if (ram_wren_b) begin mem[ram_address_b] <= ram_data_b; written[ram_address_b] <= 1'b1; end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int            m_ptr;
    logic [DW-1:0] m_rdata [N];
    logic [DW-1:0] sh_mem  [1<<AW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        req_valid[i] = 1'b1; req_wr[i] = wr; req_addr[i] = ad; req_wdata[i] = d;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_rdata[i] = '0;
    endtask

    // One clock cycle: called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic step(output logic [N-1:0] gnt);
        int            a, b, idx;
        logic [N-1:0]  g, exp_rsp;
        #1;
        a = -1; b = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) begin
                if (a < 0) a = idx;
                else if (b < 0 && !(req_addr[idx] == req_addr[a] && (req_wr[idx] || req_wr[a]))) b = idx;
            end
        end
        g = '0;
        if (a >= 0) g[a] = 1'b1;
        if (b >= 0) g[b] = 1'b1;
        check("req_ready", req_ready, g);
        if (a >= 0) begin
            check("wren_a", ram_wren_a, req_wr[a]);
            check("addr_a", ram_address_a, req_addr[a]);
            if (req_wr[a]) check("data_a", ram_data_a, req_wdata[a]);
        end else begin
            check("idle_a", {ram_wren_a, ram_address_a, ram_data_a}, 64'd0);
        end
        if (b >= 0) begin
            check("wren_b", ram_wren_b, req_wr[b]);
            check("addr_b", ram_address_b, req_addr[b]);
            if (req_wr[b]) check("data_b", ram_data_b, req_wdata[b]);
        end else begin
            check("idle_b", {ram_wren_b, ram_address_b, ram_data_b}, 64'd0);
        end
        exp_rsp = '0;
        for (int p = 0; p < 2; p++) begin
            idx = (p == 0) ? a : b;
            if (idx >= 0 && !req_wr[idx]) begin
                exp_rsp[idx] = 1'b1;
                m_rdata[idx] = sh_mem[req_addr[idx]];
            end
        end
        for (int p = 0; p < 2; p++) begin
            idx = (p == 0) ? a : b;
            if (idx >= 0 && req_wr[idx]) sh_mem[req_addr[idx]] = req_wdata[idx];
        end
        if (b >= 0) m_ptr = (b + 1) % N;
        else if (a >= 0) m_ptr = (a + 1) % N;
        @(posedge clock); #1;
        check("rsp_valid", rsp_valid, exp_rsp);
        for (int i = 0; i < N; i++) check($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i], m_rdata[i]);
        gnt = g;
        @(negedge clock);
    endtask

    typedef struct {
        logic [N-1:0]         valid;
        logic [N-1:0]         wr;
        logic [N-1:0][AW-1:0] addr;
        logic [N-1:0][DW-1:0] wdata;
        logic [N-1:0]         exp_ready;
        logic [N-1:0]         exp_rsp;
    } vec_t;

    vec_t vt [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] g;
        int           cnt [N];

        for (int i = 0; i < (1 << AW); i++) sh_mem[i] = init_word(i);
        model_reset();

        // Directed vectors, applied from reset with the pointer at 0.
        for (int i = 0; i < 7; i++) begin
            vt[i].valid = '0; vt[i].wr = '0; vt[i].addr = '0; vt[i].wdata = '0;
        end
        vt[0].valid = 4'b0001; vt[0].wr = 4'b0001; vt[0].addr[0] = 10'h005; vt[0].wdata[0] = 32'hDEADBEEF;
        vt[0].exp_ready = 4'b0001; vt[0].exp_rsp = 4'b0000;
        vt[1].valid = 4'b0001; vt[1].addr[0] = 10'h005;
        vt[1].exp_ready = 4'b0001; vt[1].exp_rsp = 4'b0001;
        vt[2].valid = 4'b0110; vt[2].addr[1] = 10'h010; vt[2].addr[2] = 10'h020;
        vt[2].exp_ready = 4'b0110; vt[2].exp_rsp = 4'b0110;
        vt[3].valid = 4'b1000; vt[3].addr[3] = 10'h000;
        vt[3].exp_ready = 4'b1000; vt[3].exp_rsp = 4'b1000;
        vt[4].valid = 4'b0011; vt[4].wr = 4'b0001; vt[4].addr[0] = 10'h3FF; vt[4].addr[1] = 10'h3FF;
        vt[4].wdata[0] = 32'h1234_5678;
        vt[4].exp_ready = 4'b0001; vt[4].exp_rsp = 4'b0000;
        vt[5].valid = 4'b0010; vt[5].addr[1] = 10'h3FF;
        vt[5].exp_ready = 4'b0010; vt[5].exp_rsp = 4'b0010;
        vt[6].valid = 4'b1100; vt[6].addr[2] = 10'h001; vt[6].addr[3] = 10'h001;
        vt[6].exp_ready = 4'b1100; vt[6].exp_rsp = 4'b1100;

        // Reset with requests already pending: nothing may be granted or driven.
        clear_inputs();
        set_req(0, 1'b1, 10'h2AA, 32'hFFFF_FFFF);
        set_req(1, 1'b0, 10'h155, '0);
        @(negedge clock); #1;
        check("rst_ready", req_ready, 4'b0000);
        check("rst_ram", {ram_wren_a, ram_wren_b, ram_address_a, ram_address_b}, 64'd0);
        check("rst_rsp_valid", rsp_valid, 4'b0000);
        check("rst_rsp_rdata0", rsp_rdata[0], 32'd0);
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            req_valid = vt[i].valid; req_wr = vt[i].wr; req_addr = vt[i].addr; req_wdata = vt[i].wdata;
            #1;
            check($sformatf("vec%0d_ready", i), req_ready, vt[i].exp_ready);
            step(g);
            check($sformatf("vec%0d_rsp", i), rsp_valid, vt[i].exp_rsp);
        end
        check("wr_rd_data", rsp_rdata[0], 32'hDEADBEEF);
        clear_inputs();

        // Fairness: four continuous readers, pointer at 0.
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(10'h040 + i), '0);
            #1;
            check($sformatf("fair%0d_ready", c), req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            for (int i = 0; i < N; i++) cnt[i] += int'(req_ready[i]);
            step(g);
        end
        for (int i = 0; i < N; i++) check($sformatf("fair_count%0d", i), cnt[i], 4);
        clear_inputs();

        // Random traffic over a small address set so conflicts and same-address reads are common.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    set_req(i, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom_range(0, 7)),
                            $urandom);
                end
            end
            step(g);
            for (int i = 0; i < N; i++) if (g[i]) req_valid[i] = 1'b0;
        end
        clear_inputs();

        // Reset asserted while a read is in flight and another is being granted.
        set_req(0, 1'b0, 10'h005, '0);
        #1;
        @(posedge clock); #1;
        set_req(2, 1'b0, 10'h010, '0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrd_rsp_valid", rsp_valid, 4'b0000);
        for (int i = 0; i < N; i++) check($sformatf("midrd_rdata%0d", i), rsp_rdata[i], 32'd0);
        check("midrd_ready", req_ready, 4'b0000);
        check("midrd_ram", {ram_wren_a, ram_wren_b, ram_address_a, ram_address_b}, 64'd0);
        @(negedge clock); @(negedge clock);
        clear_inputs();
        rst_n = 1'b1;
        model_reset();
        step(g);
        check("post_rst_rsp", rsp_valid, 4'b0000);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(10'h080 + i), '0);
        #1;
        check("post_rst_ptr", req_ready, 4'b0011);
        step(g);
        clear_inputs();
        step(g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
